// File: rtl/mic_pkg.sv
// Shared constants, types and sequencer state encoding for the microphone
// frame sequencer and its channel-scheduling helpers.
package mic_pkg;

  localparam int         MIC_NUM_CH   = 6;
  localparam int         MIC_DW       = 24;
  localparam logic [2:0] MIC_HDR_CHAN = 3'd7;

  typedef logic [2:0]        mic_chan_t;
  typedef logic [MIC_DW-1:0] mic_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mic_frame_sequencer_if.sv
// Valid/ready sample stream carrying one channel sample (or header) per beat.
interface mic_frame_sequencer_if
  import mic_pkg::*;
#(
  parameter int DW = MIC_DW
) ();

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  mic_chan_t     m_chan;
  logic          m_last;

  modport master (output m_valid, m_data, m_chan, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_chan, m_last, output m_ready);

endinterface

// File: rtl/mic_ch_pick.sv
// Combinational channel picker: next enabled channel above idx, lowest
// enabled channel, and whether idx is the highest enabled channel.
module mic_ch_pick
  import mic_pkg::*;
#(
  parameter int NUM_CH = MIC_NUM_CH
) (
  input  logic [NUM_CH-1:0] mask,
  input  mic_chan_t         idx,
  output mic_chan_t         next_idx,
  output mic_chan_t         first_idx,
  output logic              is_last
);

  // Scan downwards so the last match seen is the lowest qualifying bit.
  always_comb begin
    next_idx  = idx;
    first_idx = '0;
    is_last   = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = mic_chan_t'(i);
        if (mic_chan_t'(i) > idx) begin
          next_idx = mic_chan_t'(i);
          is_last  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mic_frame_sequencer.sv
// Captures 6-channel mic frames and serialises enabled channels onto a stream.
// Optional header beat per frame when MIC_FRAME_HEADER_EN is defined.
module mic_frame_sequencer
  import mic_pkg::*;
#(
  parameter int NUM_CH = MIC_NUM_CH,
  parameter int DW     = MIC_DW,
  parameter int FCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [NUM_CH-1:0]    cfg_ch_mask,
  input  logic [FCNT_W-1:0]    cfg_frame_num,
  input  logic                 mic_data_vld_i,
  input  logic [NUM_CH*DW-1:0] mic_data_i,
  mic_frame_sequencer_if.master m_if,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [FCNT_W-1:0]    drop_cnt,
  output logic [FCNT_W-1:0]    frame_cnt
);

  seq_state_t        state_reg;
  logic [NUM_CH-1:0] mask_reg;
  logic [FCNT_W-1:0] frame_num_reg;
  logic [FCNT_W-1:0] frame_cnt_reg;
  logic [FCNT_W-1:0] frame_cnt_next;
  logic [FCNT_W-1:0] drop_cnt_reg;
  logic [DW-1:0]     snap_reg [NUM_CH];
  logic [DW-1:0]     mic_words [NUM_CH];
  mic_chan_t         idx_reg;
  logic              stop_pending_reg;
  logic              ovf_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              m_valid_reg;
  logic              hdr_active;

  mic_chan_t pick_next;
  mic_chan_t pick_first;
  logic      pick_last;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign mic_words[gi] = mic_data_i[gi*DW +: DW];
  end

  mic_ch_pick #(.NUM_CH(NUM_CH)) u_pick (
    .mask      (mask_reg),
    .idx       (idx_reg),
    .next_idx  (pick_next),
    .first_idx (pick_first),
    .is_last   (pick_last)
  );

`ifdef MIC_FRAME_HEADER_EN
  logic hdr_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_reg <= 1'b0;
    end else if (state_reg == WAIT && !cfg_stop && mic_data_vld_i) begin
      hdr_reg <= 1'b1;
    end else if (state_reg == SEND && m_if.m_ready) begin
      hdr_reg <= 1'b0;
    end
  end
  assign hdr_active = hdr_reg;
`else
  assign hdr_active = 1'b0;
`endif

  assign frame_cnt_next = frame_cnt_reg + FCNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      mask_reg         <= '0;
      frame_num_reg    <= '0;
      frame_cnt_reg    <= '0;
      drop_cnt_reg     <= '0;
      idx_reg          <= '0;
      stop_pending_reg <= 1'b0;
      ovf_reg          <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      m_valid_reg      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_start && !cfg_stop && |cfg_ch_mask) begin
            mask_reg      <= cfg_ch_mask;
            frame_num_reg <= cfg_frame_num;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
            ovf_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (cfg_stop) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (mic_data_vld_i) begin
            snap_reg    <= mic_words;
            idx_reg     <= pick_first;
            m_valid_reg <= 1'b1;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          if (cfg_stop) stop_pending_reg <= 1'b1;
          // A new frame while still serialising is dropped, snapshot untouched.
          if (mic_data_vld_i) begin
            ovf_reg <= 1'b1;
            if (drop_cnt_reg != {FCNT_W{1'b1}}) drop_cnt_reg <= drop_cnt_reg + FCNT_W'(1);
          end
          if (m_if.m_ready && !hdr_active) begin
            if (pick_last) begin
              frame_cnt_reg <= frame_cnt_next;
              m_valid_reg   <= 1'b0;
              // A stop arriving with the final beat still ends the session.
              if ((frame_num_reg != '0 && frame_cnt_next == frame_num_reg) ||
                  stop_pending_reg || cfg_stop) begin
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                state_reg <= WAIT;
              end
            end else begin
              idx_reg <= pick_next;
            end
          end
        end
        DONE: begin
          stop_pending_reg <= 1'b0;
          busy_reg         <= 1'b0;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_if.m_valid = m_valid_reg;
  assign m_if.m_data  = hdr_active ? DW'(frame_cnt_reg) : snap_reg[idx_reg];
  assign m_if.m_chan  = hdr_active ? MIC_HDR_CHAN : idx_reg;
  assign m_if.m_last  = m_valid_reg && !hdr_active && pick_last;

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign ovf       = ovf_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule
